// File: rtl/mul_mac_seq.sv
// Multiply-accumulate sequencer: runs an N-term MAC over register-file operand
// pairs on the shared multiplier and arbitrates it against the program sequencer.
module mul_mac_seq #(
   parameter int RF_DATASIZE = 16,
   parameter int RF_ADDR     = 4,
   parameter int CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [CNT_W-1:0]       cnt,
   input  logic [RF_ADDR-1:0]     x_base,
   input  logic [RF_ADDR-1:0]     y_base,
   input  logic [3:0]             dtsts,
   input  logic                   sub,
   input  logic                   sat_en,
   input  logic                   ps_mul_en,
   input  logic                   ps_mul_otreg,
   input  logic [3:0]             ps_mul_dtsts,
   input  logic [1:0]             ps_mul_cls,
   input  logic [1:0]             ps_mul_sc,
   output logic                   mul_en,
   output logic                   mul_otreg,
   output logic [3:0]             mul_dtsts,
   output logic [1:0]             mul_cls,
   output logic [1:0]             mul_sc,
   output logic [RF_ADDR-1:0]     rf_rdx_addr,
   output logic [RF_ADDR-1:0]     rf_rdy_addr,
   input  logic [RF_DATASIZE-1:0] mul_xb_dt,
   input  logic                   mul_ps_mv,
   input  logic                   mul_ps_mn,
   output logic                   busy,
   output logic                   done,
   output logic                   ps_stall,
   output logic [RF_DATASIZE-1:0] result_lo,
   output logic [RF_DATASIZE-1:0] result_hi,
   output logic                   mv_sticky,
   output logic                   mn_last
);

   // state | meaning
   // IDLE  | multiplier controls pass through from PS; wait for start
   // PROD  | first product MR = Rx*Ry issued
   // ACC   | MR +=/-= Rx*Ry issued, one per remaining term
   // SAT   | SAT MR issued
   // RD0   | MR0 read-back issued
   // RD1   | MR1 read-back issued; MR0 on xb, captured
   // CAP   | multiplier idle; MR1 on xb, captured
   // DONE  | completion pulse; behaves like IDLE
   typedef enum logic [2:0] {
      S_IDLE, S_PROD, S_ACC, S_SAT, S_RD0, S_RD1, S_CAP, S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       rem_q, rem_d;
   logic [RF_ADDR-1:0]     xa_q, xa_d, ya_q, ya_d;
   logic [3:0]             dtsts_q, dtsts_d;
   logic                   sub_q, sub_d, sat_q, sat_d;
   logic                   en_q, en_d, otreg_q, otreg_d;
   logic [1:0]             cls_q, cls_d, sc_q, sc_d;
   logic                   busy_q, busy_d, done_q, done_d;
   logic                   op_tag_q, op_tag_d;
   logic [RF_DATASIZE-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
   logic                   mv_q, mv_d, mn_q, mn_d;

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      xa_d     = xa_q;
      ya_d     = ya_q;
      dtsts_d  = dtsts_q;
      sub_d    = sub_q;
      sat_d    = sat_q;
      en_d     = 1'b0;
      otreg_d  = 1'b0;
      cls_d    = 2'b00;
      sc_d     = 2'b00;
      done_d   = 1'b0;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      mv_d     = mv_q;
      mn_d     = mn_q;
      // flags belong to the op issued one cycle earlier
      op_tag_d = (state_q == S_PROD) || (state_q == S_ACC) || (state_q == S_SAT);
      if (op_tag_q) begin
         mv_d = mv_q | mul_ps_mv;
         mn_d = mul_ps_mn;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               dtsts_d = dtsts;
               sub_d   = sub;
               sat_d   = sat_en;
               if (cnt == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_PROD;
                  en_d    = 1'b1;
                  otreg_d = 1'b1;
                  cls_d   = 2'b01;
                  xa_d    = x_base;
                  ya_d    = y_base;
                  rem_d   = cnt - CNT_W'(1);
                  mv_d    = 1'b0;
                  mn_d    = 1'b0;
               end
            end
         end
         S_PROD, S_ACC: begin
            if (rem_q != '0) begin
               state_d = S_ACC;
               en_d    = 1'b1;
               otreg_d = 1'b1;
               cls_d   = sub_q ? 2'b11 : 2'b10;
               xa_d    = xa_q + RF_ADDR'(1);
               ya_d    = ya_q + RF_ADDR'(1);
               rem_d   = rem_q - CNT_W'(1);
            end else if (sat_q) begin
               state_d = S_SAT;
               en_d    = 1'b1;
               otreg_d = 1'b1;
               sc_d    = 2'b11;
            end else begin
               state_d = S_RD0;
               en_d    = 1'b1;
            end
         end
         S_SAT: begin
            state_d = S_RD0;
            en_d    = 1'b1;
         end
         S_RD0: begin
            state_d = S_RD1;
            en_d    = 1'b1;
            sc_d    = 2'b01;
         end
         S_RD1: begin
            state_d  = S_CAP;
            res_lo_d = mul_xb_dt;
         end
         S_CAP: begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            res_hi_d = mul_xb_dt;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         rem_q    <= '0;
         xa_q     <= '0;
         ya_q     <= '0;
         dtsts_q  <= '0;
         sub_q    <= 1'b0;
         sat_q    <= 1'b0;
         en_q     <= 1'b0;
         otreg_q  <= 1'b0;
         cls_q    <= 2'b00;
         sc_q     <= 2'b00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         op_tag_q <= 1'b0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         mv_q     <= 1'b0;
         mn_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         xa_q     <= xa_d;
         ya_q     <= ya_d;
         dtsts_q  <= dtsts_d;
         sub_q    <= sub_d;
         sat_q    <= sat_d;
         en_q     <= en_d;
         otreg_q  <= otreg_d;
         cls_q    <= cls_d;
         sc_q     <= sc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         op_tag_q <= op_tag_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         mv_q     <= mv_d;
         mn_q     <= mn_d;
      end
   end

   // PS owns the multiplier whenever the sequencer is not busy
   assign mul_en      = busy_q ? en_q    : ps_mul_en;
   assign mul_otreg   = busy_q ? otreg_q : ps_mul_otreg;
   assign mul_dtsts   = busy_q ? dtsts_q : ps_mul_dtsts;
   assign mul_cls     = busy_q ? cls_q   : ps_mul_cls;
   assign mul_sc      = busy_q ? sc_q    : ps_mul_sc;
   assign rf_rdx_addr = xa_q;
   assign rf_rdy_addr = ya_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign ps_stall    = busy_q & ps_mul_en;
   assign result_lo   = res_lo_q;
   assign result_hi   = res_hi_q;
   assign mv_sticky   = mv_q;
   assign mn_last     = mn_q;

endmodule
